// File: rtl/imem_ctrl.sv
// imem_ctrl: owner of the single instruction-memory port.
// Zero-fills the array after reset, then takes loader writes, then serves
// core fetches with loader writes still taking priority over fetches.
module imem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  // core fetch port
  input  logic              fetch_req_i,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              fetch_ready_o,
  output logic              fetch_valid_o,
  output logic [31:0]       fetch_instr_o,
  output logic              fetch_fault_o,
  // loader / debug port
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i,
  output logic              load_ready_o,
  input  logic              load_done_i,
  output logic              core_run_o,
  // memory array port (synchronous read)
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  // state    | meaning
  // ST_CLEAR | zero-filling the array, one word per cycle
  // ST_LOAD  | accepting loader writes until load_done
  // ST_RUN   | serving fetches; loader writes take priority
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                fvalid_q;
  logic                ffault_q;

  logic                pc_fault;
  logic [ADDR_W-1:0]   pc_idx;
  logic                load_ready;
  logic                fetch_ready;
  logic                load_fire;
  logic                fetch_fire;
  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [31:0]         mem_wdata_d;

  // PC decode: word index plus fault on misalignment or bits above the array
  assign pc_idx   = fetch_pc_i[ADDR_W+1:2];
  assign pc_fault = (|fetch_pc_i[1:0]) | (|fetch_pc_i[XLEN-1:ADDR_W+2]);

  // Port arbitration: clear fill, then loader, then fetch; idle holds the address
  always_comb begin
    load_ready  = 1'b0;
    fetch_ready = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = addr_q;
    mem_wdata_d = '0;
    if (!reset) begin
      load_ready  = (state_q == ST_LOAD) || (state_q == ST_RUN);
      fetch_ready = (state_q == ST_RUN) && !load_valid_i;
    end
    load_fire  = load_valid_i && load_ready;
    fetch_fire = fetch_req_i && fetch_ready;
    if (reset) begin
      mem_addr_d = '0;
    end else if (state_q == ST_CLEAR) begin
      mem_we_d   = 1'b1;
      mem_addr_d = clr_cnt_q;
    end else if (load_fire) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = load_addr_i;
      mem_wdata_d = load_data_i;
    end else if (fetch_fire && !pc_fault) begin
      mem_addr_d = pc_idx;
    end
  end

  // Sequencer: state, clear counter, held address and fetch response flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      fvalid_q  <= 1'b0;
      ffault_q  <= 1'b0;
    end else begin
      addr_q   <= mem_addr_d;
      fvalid_q <= fetch_fire;
      ffault_q <= fetch_fire && pc_fault;
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_WORD) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_done_i) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign fetch_ready_o = fetch_ready;
  assign load_ready_o  = load_ready;
  assign core_run_o    = (state_q == ST_RUN);
  assign fetch_valid_o = fvalid_q;
  assign fetch_fault_o = ffault_q;
  // the array data arrives one cycle after the address, aligned with fvalid_q
  assign fetch_instr_o = (fvalid_q && !ffault_q) ? mem_rdata_i : 32'd0;
  assign mem_we_o      = mem_we_d;
  assign mem_addr_o    = mem_addr_d;
  assign mem_wdata_o   = mem_wdata_d;

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized self-checking bench for imem_ctrl with an array model and a
// word-level reference of array contents and fetch responses.
module tb_imem_ctrl;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int XLEN   = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [XLEN-1:0]   fetch_pc;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_fault;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              load_ready;
  logic              load_done;
  logic              core_run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  imem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_req_i   (fetch_req),
    .fetch_pc_i    (fetch_pc),
    .fetch_ready_o (fetch_ready),
    .fetch_valid_o (fetch_valid),
    .fetch_instr_o (fetch_instr),
    .fetch_fault_o (fetch_fault),
    .load_valid_i  (load_valid),
    .load_addr_i   (load_addr),
    .load_data_i   (load_data),
    .load_ready_o  (load_ready),
    .load_done_i   (load_done),
    .core_run_o    (core_run),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read array; scramble fills it with garbage before the zero-fill
  logic [31:0] arr [DEPTH];
  logic        scramble = 1'b1;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= $urandom();
    end else if (mem_we) begin
      arr[mem_addr] <= mem_wdata;
    end
    mem_rdata <= arr[mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: expected array contents, last driven address, pending response
  logic [31:0]       ref_mem [DEPTH];
  logic [ADDR_W-1:0] last_addr = '0;
  bit                pend_v = 1'b0;
  bit                pend_fault = 1'b0;
  logic [31:0]       pend_instr = '0;

  function automatic bit pc_bad(input logic [63:0] pc);
    return ((pc % 64'd4) != 64'd0) || (pc >= 64'(DEPTH) * 64'd4);
  endfunction

  task automatic chk_array(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (arr[i] !== ref_mem[i]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset      = 1'b1;
      fetch_req  = 1'b1;
      fetch_pc   = 64'd0;
      load_valid = 1'($urandom_range(0, 1));
      load_addr  = ADDR_W'($urandom());
      load_data  = $urandom();
      load_done  = 1'($urandom_range(0, 1));
      #1;
      if (k == 0) begin
        chk("rst_in_flight_valid", 64'(fetch_valid), 64'(pend_v));
      end else begin
        chk("rst_values", 64'({fetch_valid, fetch_fault, fetch_instr, load_ready, core_run,
                               mem_we, mem_addr, mem_wdata}), 64'd0);
      end
    end
    pend_v    = 1'b0;
    last_addr = '0;
  endtask

  task automatic clear_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset      = 1'b0;
      fetch_req  = 1'($urandom_range(0, 1));
      fetch_pc   = {$urandom(), $urandom()} & 64'hFFC;
      load_valid = 1'($urandom_range(0, 1));
      load_addr  = ADDR_W'($urandom());
      load_data  = $urandom();
      load_done  = 1'($urandom_range(0, 1));
      #1;
      chk("clear_cycle", 64'({mem_we, mem_addr, mem_wdata, load_ready, fetch_ready, core_run, fetch_valid}),
          64'({1'b1, ADDR_W'(i), 32'd0, 4'b0000}));
      ref_mem[i] = 32'd0;
      last_addr  = ADDR_W'(i);
    end
  endtask

  task automatic load_cycle(input bit lv, input logic [ADDR_W-1:0] la, input logic [31:0] ld, input bit done);
    @(negedge clk);
    reset      = 1'b0;
    fetch_req  = 1'($urandom_range(0, 1));
    fetch_pc   = 64'($urandom_range(0, 63)) * 64'd4;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    load_done  = done;
    #1;
    chk("load_status", 64'({load_ready, fetch_ready, core_run, fetch_valid}), 64'({1'b1, 3'b000}));
    if (lv) begin
      chk("load_write", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, la, ld}));
      ref_mem[la] = ld;
      last_addr   = la;
    end else begin
      chk("load_idle", 64'({mem_we, mem_addr}), 64'({1'b0, last_addr}));
    end
  endtask

  task automatic run_cycle(input bit req, input logic [63:0] pc, input bit lv,
                           input logic [ADDR_W-1:0] la, input logic [31:0] ld, output bit accepted);
    @(negedge clk);
    reset      = 1'b0;
    fetch_req  = req;
    fetch_pc   = pc;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    load_done  = 1'($urandom_range(0, 1));
    #1;
    chk("run_core_run", 64'(core_run), 64'd1);
    chk("fetch_valid", 64'(fetch_valid), 64'(pend_v));
    chk("fetch_fault", 64'(fetch_fault), 64'(pend_v && pend_fault));
    chk("fetch_instr", 64'(fetch_instr), pend_v ? 64'(pend_instr) : 64'd0);
    chk("fetch_ready", 64'(fetch_ready), 64'(!lv));
    chk("run_load_ready", 64'(load_ready), 64'd1);
    accepted = req && !lv;
    if (lv) begin
      chk("run_write", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, la, ld}));
      ref_mem[la] = ld;
      last_addr   = la;
    end else if (accepted && !pc_bad(pc)) begin
      chk("fetch_addr", 64'({mem_we, mem_addr}), 64'({1'b0, ADDR_W'(pc / 64'd4)}));
      last_addr = ADDR_W'(pc / 64'd4);
    end else begin
      chk("run_idle", 64'({mem_we, mem_addr}), 64'({1'b0, last_addr}));
    end
    pend_v = accepted;
    if (accepted) begin
      pend_fault = pc_bad(pc);
      pend_instr = pend_fault ? 32'd0 : ref_mem[int'(pc / 64'd4)];
    end
  endtask

  initial begin
    bit              acc;
    bit              hold;
    logic [63:0]     hpc;
    int              r;
    logic [63:0]     pc;
    bit              lv;

    reset = 1'b1; fetch_req = 1'b0; fetch_pc = '0; load_valid = 1'b0;
    load_addr = '0; load_data = '0; load_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

    reset_cycles(2);
    scramble = 1'b0;

    // partial fill, reset at count 500, then a complete fill from 0
    clear_cycles(500);
    reset_cycles(2);
    clear_cycles(DEPTH);
    load_cycle(1'b0, '0, '0, 1'b0);
    chk_array("zero_fill");

    for (int i = 0; i < 20; i++) begin
      load_cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(3, 63)), $urandom(), 1'b0);
    end
    load_cycle(1'b1, 10'd0, 32'h0050_0093, 1'b0);
    load_cycle(1'b1, 10'd1, 32'h0010_0113, 1'b0);
    load_cycle(1'b1, 10'd2, 32'h0020_81B3, 1'b1);

    // directed fetches, faults and loader/fetch collision
    run_cycle(1'b1, 64'h8, 1'b0, '0, '0, acc);
    run_cycle(1'b1, 64'h0, 1'b0, '0, '0, acc);
    chk("instr_at_8", 64'(fetch_instr), 64'h0020_81B3);
    run_cycle(1'b1, 64'h4, 1'b0, '0, '0, acc);
    run_cycle(1'b1, 64'h6, 1'b0, '0, '0, acc);
    run_cycle(1'b1, 64'h1000, 1'b0, '0, '0, acc);
    run_cycle(1'b0, 64'h0, 1'b0, '0, '0, acc);
    run_cycle(1'b1, 64'h4, 1'b1, 10'd5, 32'hCAFE_0005, acc);
    run_cycle(1'b1, 64'h4, 1'b0, '0, '0, acc);
    run_cycle(1'b1, 64'h14, 1'b0, '0, '0, acc);
    run_cycle(1'b0, 64'h0, 1'b0, '0, '0, acc);
    chk_array("array_after_directed");

    // randomized traffic; a refused request is held unchanged by the core
    hold = 1'b0; hpc = '0;
    for (int i = 0; i < 300; i++) begin
      if (hold) begin
        pc = hpc;
      end else begin
        r = int'($urandom_range(0, 9));
        case (r)
          6:       pc = 64'($urandom_range(0, 255)) | 64'd1;
          7:       pc = 64'($urandom_range(DEPTH, 2 * DEPTH)) * 64'd4;
          8:       pc = (64'($urandom_range(0, 63)) * 64'd4) | (64'd1 << $urandom_range(12, 63));
          9:       pc = 64'(DEPTH - 1) * 64'd4;
          default: pc = 64'($urandom_range(0, 63)) * 64'd4;
        endcase
      end
      lv = ($urandom_range(0, 3) == 0);
      run_cycle(hold ? 1'b1 : 1'($urandom_range(0, 3) != 0), pc, lv,
                ($urandom_range(0, 7) == 0) ? ADDR_W'(DEPTH - 1) : ADDR_W'($urandom_range(0, 63)),
                $urandom(), acc);
      hold = fetch_req && !acc;
      hpc  = pc;
    end
    run_cycle(1'b0, 64'h0, 1'b0, '0, '0, acc);
    chk_array("array_after_random");

    // reset with a fetch response in flight, then a full refill
    run_cycle(1'b1, 64'h0, 1'b0, '0, '0, acc);
    reset_cycles(2);
    clear_cycles(DEPTH);
    load_cycle(1'b0, '0, '0, 1'b0);
    chk_array("refill_after_run_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Controller that owns the single port of the instruction memory array and sequences its use. After reset it zero-fills the array one word per cycle. It then accepts program-load writes from a boot loader. Once loading is done it serves instruction fetches from the core, with loader writes still permitted at higher priority. The block sits between the core fetch stage, the loader/debug port and a synchronous-read memory array.

Parameters:
DEPTH, 1024, number of 32-bit instruction words in the array
ADDR_W, 10, word-address width; must equal log2(DEPTH)
XLEN, 64, width of the core PC

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
fetch_req  in  1  core requests an instruction at fetch_pc
fetch_pc  in  XLEN  byte address of the instruction
fetch_ready  out  1  request accepted this cycle when fetch_req & fetch_ready
fetch_valid  out  1  response valid; one-cycle pulse per accepted request
fetch_instr  out  32  fetched instruction word; 0 on fault
fetch_fault  out  1  qualifies fetch_valid; misaligned or out-of-range PC
load_valid  in  1  loader write request
load_addr  in  ADDR_W  word address for the loader write
load_data  in  32  loader write data
load_ready  out  1  loader write accepted when load_valid & load_ready
load_done  in  1  loader finished; start execution
core_run  out  1  high while in RUN; core holds its PC while low
mem_we  out  1  array write enable
mem_addr  out  ADDR_W  array word address
mem_wdata  out  32  array write data
mem_rdata  in  32  array read data; registered, valid one cycle after mem_addr

Behaviour:
- Reset is synchronous, active-high, on clk.
  - Reset values: state=CLEAR, clear counter=0, fetch_ready=0, fetch_valid=0, fetch_fault=0, fetch_instr=0, load_ready=0, core_run=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States are CLEAR, LOAD and RUN.
- CLEAR:
  - Each cycle drives mem_we=1, mem_addr=counter, mem_wdata=0, then increments the counter.
  - After the write to DEPTH-1, moves to LOAD. CLEAR therefore lasts exactly DEPTH cycles after reset deasserts.
  - load_ready=0 and fetch_ready=0 throughout. load_valid and load_done are ignored.
- LOAD:
  - load_ready=1.
  - On load_valid: mem_we=1, mem_addr=load_addr, mem_wdata=load_data in the same cycle (combinational pass-through of the registered state decision).
  - On load_done: moves to RUN next edge. A write presented in the same cycle as load_done is still performed.
  - fetch_ready=0.
- RUN:
  - core_run=1.
  - Loader has priority. On load_valid, the write is performed and fetch_ready=0 that cycle.
  - Otherwise fetch_ready=1.
  - load_done is ignored.
- Fetch address decode:
  - word index = fetch_pc[ADDR_W+1:2].
  - Fault when fetch_pc[1:0] != 0 or fetch_pc[XLEN-1:ADDR_W+2] != 0.
  - A faulting request is accepted but issues no array access.
- Fetch latency:
  - A request accepted in cycle N gives fetch_valid=1 in cycle N+1, with fetch_instr=mem_rdata (or 0 with fetch_fault=1).
  - Back-to-back requests sustain one instruction per cycle.
  - fetch_valid is low in any cycle whose preceding cycle accepted no request.
- A non-accepted request (fetch_ready=0) must be held by the core. The controller keeps no request buffer.
- mem_we=0 whenever no write is performed.
  - When fetching, mem_addr = word index.
  - When idle, mem_addr holds its last value.
- Reset mid-operation, in any state:
  - Returns to CLEAR with counter 0 and restarts the full fill.
  - The in-flight fetch response is dropped: fetch_valid=0 after the reset edge.

Test Plan:
- Reset 2 cycles, then release -> mem_we=1 for exactly 1024 consecutive cycles, mem_addr 0..1023 in order, mem_wdata=0; then load_ready=1 and core_run=0.
- In LOAD, write 0x00500093@0, 0x00100113@1, 0x002081B3@2, with load_done asserted alongside the last write -> all three written; core_run=1 on the next edge.
- In RUN, fetch_pc=0x8 accepted in cycle N -> fetch_valid=1 in N+1, fetch_instr=0x002081B3, fetch_fault=0. Then pc 0x0 and 0x4 back-to-back -> two consecutive valid responses in order.
- Fetch_pc=0x6 -> fetch_fault=1, fetch_instr=0. Fetch_pc=0x1000 -> fault. In both cases mem_we=0 and the array is unchanged.
- In RUN, load_valid and fetch_req together -> write performed, fetch_ready=0, fetch_valid=0 next cycle; the held request is served on the following cycle.
- Reset asserted at clear count 500 -> counter restarts at 0; load_ready stays low for the full 1024-cycle fill. Reset during RUN with a fetch outstanding -> no fetch_valid after reset.
